// File: rtl/pipeexe_mc_if.sv
// rtl/pipeexe_mc_if.sv - ID-to-execute handshake and EX/MEM result bundle
interface pipeexe_mc_if #(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
);
    logic             ein_valid;
    logic             ein_ready;
    logic             eflush;
    logic [3:0]       ealuc;
    logic             ealuimm;
    logic             eshift;
    logic             ejal;
    logic             emul;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] eimm;
    logic [WIDTH-1:0] epc4;
    logic [RN_W-1:0]  ern0;
    logic             eout_valid;
    logic [RN_W-1:0]  ern;
    logic [WIDTH-1:0] ealu;
    logic             ebusy;

    modport master (
        output ein_valid, eflush, ealuc, ealuimm, eshift, ejal, emul,
               ea, eb, eimm, epc4, ern0,
        input  ein_ready, eout_valid, ern, ealu, ebusy
    );

    modport slave (
        input  ein_valid, eflush, ealuc, ealuimm, eshift, ejal, emul,
               ea, eb, eimm, epc4, ern0,
        output ein_ready, eout_valid, ern, ealu, ebusy
    );
endinterface

// File: rtl/pipeexe_mc.sv
// rtl/pipeexe_mc.sv - registered execute stage with ALU, jal link and iterative multiplier
module pipeexe_mc #(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
) (
    input  logic         clock,
    input  logic         resetn,
    pipeexe_mc_if.slave  ex
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] ealu_q, ealu_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [RN_W-1:0]  dest_q, dest_d;
    logic [RN_W-1:0]  ern_q, ern_d;
    logic             eout_valid_q, eout_valid_d;

    logic [WIDTH-1:0] shamt;
    logic [WIDTH-1:0] alua;
    logic [WIDTH-1:0] alub;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;
    logic [SHW-1:0]   sh_amt;
    logic [RN_W-1:0]  dest_in;
    logic             accept;

    // Shift amount lives in immediate bits [6 +: SHW]; the shift-then-cast keeps narrow widths in range.
    assign shamt   = {{(WIDTH-SHW){1'b0}}, SHW'(ex.eimm >> 6)};
    assign alua    = ex.eshift  ? shamt   : ex.ea;
    assign alub    = ex.ealuimm ? ex.eimm : ex.eb;
    assign sh_amt  = alua[SHW-1:0];
    assign dest_in = ex.ejal ? {RN_W{1'b1}} : ex.ern0;
    assign accept  = ex.ein_valid & (state_q == S_IDLE) & ~ex.eflush;
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu_res = '0;
        casez (ex.ealuc)
            4'b?000: alu_res = alua + alub;
            4'b?100: alu_res = alua - alub;
            4'b?001: alu_res = alua & alub;
            4'b?101: alu_res = alua | alub;
            4'b?010: alu_res = alua ^ alub;
            4'b?110: alu_res = alub << (WIDTH / 2);
            4'b0011: alu_res = alub << sh_amt;
            4'b0111: alu_res = alub >> sh_amt;
            4'b1111: alu_res = $unsigned($signed(alub) >>> sh_amt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ex.eflush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept && ex.emul && !ex.ejal) state_d = S_MUL;
                S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ex.ein_ready  = (state_q == S_IDLE);
        ex.ebusy      = (state_q == S_MUL);
        ex.eout_valid = eout_valid_q;
        ex.ealu       = ealu_q;
        ex.ern        = ern_q;
    end

    // Flush leaves ealu/ern untouched; only the valid pulse and the multiply are cancelled.
    always_comb begin
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        dest_d       = dest_q;
        ealu_d       = ealu_q;
        ern_d        = ern_q;
        eout_valid_d = 1'b0;
        if (!ex.eflush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (ex.ejal) begin
                            ealu_d       = ex.epc4 + WIDTH'(4);
                            ern_d        = dest_in;
                            eout_valid_d = 1'b1;
                        end else if (ex.emul) begin
                            acc_d    = '0;
                            mcand_d  = alua;
                            mplier_d = alub;
                            cnt_d    = SHW'(WIDTH - 1);
                            dest_d   = dest_in;
                        end else begin
                            ealu_d       = alu_res;
                            ern_d        = dest_in;
                            eout_valid_d = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        ealu_d       = acc_step;
                        ern_d        = dest_q;
                        eout_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            dest_q       <= '0;
            ealu_q       <= '0;
            ern_q        <= '0;
            eout_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            dest_q       <= dest_d;
            ealu_q       <= ealu_d;
            ern_q        <= ern_d;
            eout_valid_q <= eout_valid_d;
        end
    end
endmodule

// File: tb/tb_pipeexe_mc.sv
// tb/tb_pipeexe_mc.sv - directed-vector bench for pipeexe_mc at WIDTH 32 and 16
module tb_pipeexe_mc;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    pipeexe_mc_if #(.WIDTH(32), .RN_W(5)) ia ();
    pipeexe_mc_if #(.WIDTH(16), .RN_W(4)) ib ();

    pipeexe_mc #(.WIDTH(32), .RN_W(5)) u_a (.clock(clock), .resetn(resetn), .ex(ia));
    pipeexe_mc #(.WIDTH(16), .RN_W(4)) u_b (.clock(clock), .resetn(resetn), .ex(ib));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] aluc, input logic isel, input logic sh,
                           input logic jal, input logic mul, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] pc4, input logic [4:0] rn0);
        ia.ealuc = aluc; ia.ealuimm = isel; ia.eshift = sh; ia.ejal = jal; ia.emul = mul;
        ia.ea = a; ia.eb = b; ia.eimm = imm; ia.epc4 = pc4; ia.ern0 = rn0;
        ia.ein_valid = 1'b1;
    endtask

    task automatic drive_b(input logic [3:0] aluc, input logic isel, input logic sh,
                           input logic jal, input logic mul, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] imm,
                           input logic [15:0] pc4, input logic [3:0] rn0);
        ib.ealuc = aluc; ib.ealuimm = isel; ib.eshift = sh; ib.ejal = jal; ib.emul = mul;
        ib.ea = a; ib.eb = b; ib.eimm = imm; ib.epc4 = pc4; ib.ern0 = rn0;
        ib.ein_valid = 1'b1;
    endtask

    // Called right after the accepting edge; counts edges until the result pulse.
    task automatic run_mul(input bit use_b, output int edges, output int busy_n, output int ready_n);
        edges = 0; busy_n = 0; ready_n = 0;
        while ((use_b ? ib.eout_valid : ia.eout_valid) !== 1'b1 && edges < 200) begin
            if ((use_b ? ib.ebusy : ia.ebusy) === 1'b1) busy_n++;
            if ((use_b ? ib.ein_ready : ia.ein_ready) === 1'b1) ready_n++;
            step();
            edges++;
        end
    endtask

    task automatic accept_a();
        step();
        ia.ein_valid = 1'b0;
        ia.eflush = 1'b0;
    endtask

    initial begin
        int edges, busy_n, ready_n, pulses;

        ia.eflush = 1'b0; ib.eflush = 1'b0; ib.ein_valid = 1'b0;
        drive_b(4'd0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        ib.ein_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive_a(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom, 5'($urandom));
            step();
        end
        chk("rst_valid", ia.eout_valid, 0);
        chk("rst_ealu",  ia.ealu, 0);
        chk("rst_ern",   ia.ern, 0);
        chk("rst_ready", ia.ein_ready, 1);
        chk("rst_busy",  ia.ebusy, 0);
        ia.ein_valid = 1'b0;
        resetn = 1'b1;
        step();

        // back-to-back ALU vectors, each checked one edge after acceptance
        drive_a(4'b0000, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd5);
        step();
        chk("add_valid", ia.eout_valid, 1);
        chk("add_ealu",  ia.ealu, 32'h0);
        chk("add_ern",   ia.ern, 5);
        drive_a(4'b0100, 0, 0, 0, 0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd6);
        step();
        chk("sub_valid", ia.eout_valid, 1);
        chk("sub_ealu",  ia.ealu, 32'hFFFFFFFE);
        drive_a(4'b1111, 0, 1, 0, 0, 32'h0, 32'h80000000, 32'h100, 32'h0, 5'd7);
        step();
        chk("sra_ealu",  ia.ealu, 32'hF8000000);
        drive_a(4'b0110, 1, 0, 0, 0, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd8);
        step();
        chk("lui_valid", ia.eout_valid, 1);
        chk("lui_ealu",  ia.ealu, 32'h12340000);
        drive_a(4'b0111, 0, 1, 0, 0, 32'h0, 32'hF0000000, 32'h200, 32'h0, 5'd8);
        step();
        chk("srl_ealu",  ia.ealu, 32'h00F00000);
        drive_a(4'b0010, 0, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 5'd8);
        step();
        chk("xor_ealu",  ia.ealu, 32'hF0F0F0F0);
        drive_a(4'b1001, 0, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 5'd8);
        step();
        chk("and_ealu",  ia.ealu, 32'h0F000F00);
        drive_a(4'b1011, 0, 0, 0, 0, 32'h1, 32'h1, 32'h0, 32'h0, 5'd8);
        accept_a();
        chk("undef_ealu", ia.ealu, 32'h0);
        step();
        chk("idle_valid", ia.eout_valid, 0);
        chk("idle_hold",  ia.ealu, 32'h0);

        drive_a(4'b0000, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h00400010, 5'd3);
        accept_a();
        chk("jal_valid", ia.eout_valid, 1);
        chk("jal_ealu",  ia.ealu, 32'h00400014);
        chk("jal_ern",   ia.ern, 31);

        drive_a(4'b0000, 0, 0, 0, 1, 32'h00010003, 32'h5, 32'h0, 32'h0, 5'd9);
        accept_a();
        chk("mul_start_valid", ia.eout_valid, 0);
        run_mul(0, edges, busy_n, ready_n);
        chk("mul_edges",  edges, 32);
        chk("mul_busy_n", busy_n, 32);
        chk("mul_ready_n", ready_n, 0);
        chk("mul_ealu",   ia.ealu, 32'h0005000F);
        chk("mul_ern",    ia.ern, 9);
        chk("mul_ready_after", ia.ein_ready, 1);
        step();
        chk("mul_pulse_one", ia.eout_valid, 0);

        drive_a(4'b0000, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd12);
        accept_a();
        run_mul(0, edges, busy_n, ready_n);
        chk("mulff_edges", edges, 32);
        chk("mulff_ealu",  ia.ealu, 32'h1);

        drive_a(4'b0000, 0, 0, 0, 1, 32'd3, 32'd4, 32'h0, 32'h0, 5'd7);
        accept_a();
        for (int i = 0; i < 9; i++) step();
        ia.eflush = 1'b1;
        step();
        ia.eflush = 1'b0;
        chk("flush_ready", ia.ein_ready, 1);
        chk("flush_busy",  ia.ebusy, 0);
        chk("flush_valid", ia.eout_valid, 0);
        chk("flush_ealu",  ia.ealu, 32'h1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ia.eout_valid === 1'b1) pulses++;
        end
        chk("flush_no_pulse", pulses, 0);

        drive_a(4'b0000, 0, 0, 0, 0, 32'd10, 32'd20, 32'h0, 32'h0, 5'd2);
        ia.eflush = 1'b1;
        accept_a();
        chk("flushacc_valid", ia.eout_valid, 0);
        chk("flushacc_ealu",  ia.ealu, 32'h1);
        chk("flushacc_ern",   ia.ern, 12);

        drive_a(4'b0000, 0, 0, 1, 1, 32'd6, 32'd6, 32'h0, 32'h100, 5'd4);
        accept_a();
        chk("jalmul_busy", ia.ebusy, 0);
        chk("jalmul_ealu", ia.ealu, 32'h104);
        chk("jalmul_ern",  ia.ern, 31);

        drive_a(4'b0000, 0, 0, 0, 1, 32'd7, 32'd9, 32'h0, 32'h0, 5'd1);
        accept_a();
        for (int i = 0; i < 5; i++) step();
        resetn = 1'b0;
        #1;
        chk("rstmul_busy",  ia.ebusy, 0);
        chk("rstmul_ready", ia.ein_ready, 1);
        chk("rstmul_ealu",  ia.ealu, 0);
        step();
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ia.eout_valid === 1'b1) pulses++;
        end
        chk("rstmul_no_pulse", pulses, 0);

        drive_b(4'b0000, 0, 0, 0, 1, 16'h00FF, 16'h0101, 16'h0, 16'h0, 4'd6);
        step();
        ib.ein_valid = 1'b0;
        run_mul(1, edges, busy_n, ready_n);
        chk("w16_mul_edges", edges, 16);
        chk("w16_mul_busy",  busy_n, 16);
        chk("w16_mul_ealu",  ib.ealu, 16'hFFFF);
        chk("w16_mul_ern",   ib.ern, 6);
        drive_b(4'b0000, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0010, 4'd2);
        step();
        chk("w16_jal_ealu", ib.ealu, 16'h0014);
        chk("w16_jal_ern",  ib.ern, 15);
        drive_b(4'b0011, 0, 1, 0, 0, 16'h0, 16'h0005, 16'h04C0, 16'h0, 4'd3);
        step();
        ib.ein_valid = 1'b0;
        chk("w16_sll_ealu", ib.ealu, 16'h0028);
        chk("w16_sll_ern",  ib.ern, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
